// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: streams input/weight pairs through an external sign-magnitude multiplier and accumulates one result per neuron.
// Latency: in_len+2 cycles per neuron; done pulses one cycle after the last neuron's write.
// Backpressure: none; reads issue every RUN cycle and results are presented for exactly one cycle.
module fc_layer_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_LEN_W   = 10,
   parameter int OUT_LEN_W  = 8,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [IN_LEN_W-1:0]           in_len,
   input  logic [OUT_LEN_W-1:0]          out_len,
   input  logic                          relu_en,
   output logic                          busy,
   output logic                          done,
   output logic                          rd_en,
   output logic [IN_LEN_W-1:0]           in_addr,
   output logic [IN_LEN_W+OUT_LEN_W-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [DATA_WIDTH-1:0]         w_data,
   output logic [DATA_WIDTH-1:0]         mul_a,
   output logic [DATA_WIDTH-1:0]         mul_b,
   input  logic [2*DATA_WIDTH-1:0]       mul_result,
   output logic                          out_valid,
   output logic [OUT_LEN_W-1:0]          out_addr,
   output logic [ACC_WIDTH-1:0]          out_data
);
   localparam int WA_W = IN_LEN_W + OUT_LEN_W;
   localparam int PAD  = ACC_WIDTH - (2*DATA_WIDTH - 1);
   localparam logic [IN_LEN_W-1:0]  I_ONE  = IN_LEN_W'(1);
   localparam logic [OUT_LEN_W-1:0] J_ONE  = OUT_LEN_W'(1);
   localparam logic [WA_W-1:0]      WA_ONE = WA_W'(1);

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, WRITE, FINISH} state_t;

   state_t                 state;
   logic [IN_LEN_W-1:0]    len_q, i;
   logic [OUT_LEN_W-1:0]   nout_q, j;
   logic                   relu_q, dv;
   logic [ACC_WIDTH-1:0]   acc, mag, addend, acc_sum, relu_sum;

   assign mul_a   = in_data;
   assign mul_b   = w_data;
   assign in_addr = i;

   // Sign-magnitude product to two's complement; a negative zero negates to zero.
   assign mag      = {{PAD{1'b0}}, mul_result[2*DATA_WIDTH-2:0]};
   assign addend   = !dv ? '0 : (mul_result[2*DATA_WIDTH-1] ? -mag : mag);
   assign acc_sum  = acc + addend;
   assign relu_sum = (relu_q && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         dv        <= 1'b0;
         out_valid <= 1'b0;
         w_addr    <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         acc       <= '0;
         i         <= '0;
         j         <= '0;
         len_q     <= '0;
         nout_q    <= '0;
         relu_q    <= 1'b0;
      end else begin
         dv        <= rd_en;
         done      <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (in_len != '0 && out_len != '0) begin
                     len_q  <= in_len;
                     nout_q <= out_len;
                     relu_q <= relu_en;
                     i      <= '0;
                     j      <= '0;
                     w_addr <= '0;
                     acc    <= '0;
                     rd_en  <= 1'b1;
                     state  <= RUN;
                  end else begin
                     done  <= 1'b1;
                     state <= FINISH;
                  end
               end
            end
            RUN: begin
               acc    <= acc_sum;
               // Running weight address walks j*in_len+i without a multiplier.
               w_addr <= w_addr + WA_ONE;
               if (i == len_q - I_ONE) begin
                  rd_en <= 1'b0;
                  state <= FLUSH;
               end else begin
                  i <= i + I_ONE;
               end
            end
            FLUSH: begin
               acc       <= acc_sum;
               out_valid <= 1'b1;
               out_addr  <= j;
               out_data  <= relu_sum;
               state     <= WRITE;
            end
            WRITE: begin
               acc <= '0;
               i   <= '0;
               if (j == nout_q - J_ONE) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  j     <= j + J_ONE;
                  rd_en <= 1'b1;
                  state <= RUN;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: directed vector table, randomized layers against a sum-of-products model,
// plus mid-layer reset and start-while-busy sequences.
module tb_fc_layer_sequencer;
   localparam int DW = 16, IW = 10, OW = 8, AW = 40, WW = IW + OW;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0;
   logic [IW-1:0] in_len = '0;
   logic [OW-1:0] out_len = '0;
   logic          busy, done, rd_en, out_valid;
   logic [IW-1:0] in_addr;
   logic [WW-1:0] w_addr;
   logic [DW-1:0] in_data = '0, w_data = '0, mul_a, mul_b;
   logic [2*DW-1:0] mul_result;
   logic [OW-1:0] out_addr;
   logic [AW-1:0] out_data;

   logic [DW-1:0] in_mem [0:1023];
   logic [DW-1:0] w_mem  [0:4095];
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   fc_layer_sequencer #(.DATA_WIDTH(DW), .IN_LEN_W(IW), .OUT_LEN_W(OW), .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_len(in_len), .out_len(out_len),
      .relu_en(relu_en), .busy(busy), .done(done), .rd_en(rd_en), .in_addr(in_addr),
      .w_addr(w_addr), .in_data(in_data), .w_data(w_data), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data));

   // External sign-magnitude multiplier and synchronous buffers.
   always_comb mul_result = {mul_a[DW-1] ^ mul_b[DW-1],
                             {{DW{1'b0}}, mul_a[DW-2:0]} * {{DW{1'b0}}, mul_b[DW-2:0]}};

   always @(posedge clk) begin
      if (rd_en) begin
         in_data <= in_mem[in_addr];
         w_data  <= w_mem[w_addr[11:0]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] model_out(input int len, input int j, input bit relu);
      longint s = 0;
      longint m;
      for (int i = 0; i < len; i++) begin
         logic [DW-1:0] a, b;
         a = in_mem[i];
         b = w_mem[j*len + i];
         m = longint'(a[DW-2:0]) * longint'(b[DW-2:0]);
         s = (a[DW-1] ^ b[DW-1]) ? s - m : s + m;
      end
      if (relu && s < 0) s = 0;
      return AW'(s);
   endfunction

   task automatic fill_random(input int len, input int nout);
      for (int i = 0; i < len; i++) begin
         in_mem[i] = DW'($urandom);
         if ($urandom_range(0, 7) == 0) in_mem[i] = 16'h8000;
      end
      for (int k = 0; k < len*nout; k++) begin
         w_mem[k] = DW'($urandom);
         if ($urandom_range(0, 7) == 0) w_mem[k] = 16'h8000;
      end
   endtask

   task automatic load_pat(input int pat);
      case (pat)
         0: begin in_mem[0] = 2; in_mem[1] = 3; in_mem[2] = 4;
                  w_mem[0] = 16'h0001; w_mem[1] = 16'h8001; w_mem[2] = 16'h0002; end
         1: begin in_mem[0] = 2; in_mem[1] = 3; in_mem[2] = 4;
                  w_mem[0] = 16'h8001; w_mem[1] = 16'h8001; w_mem[2] = 16'h8001; end
         2: begin in_mem[0] = 1; in_mem[1] = 2;
                  for (int k = 0; k < 6; k++) w_mem[k] = DW'(k + 1); end
         3: begin in_mem[0] = 16'h8000; w_mem[0] = 16'h0005; end
         default: ;
      endcase
   endtask

   // Runs one layer from start and checks timing, read addresses and results against the model.
   task automatic run_layer(input int len, input int nout, input bit relu, input int pulse_cyc,
                            input string tag, output logic [AW-1:0] first_out,
                            output int got_done, output int got_n);
      int exp_done, exp_n, exp_rd, ndone, busy_bad;
      int oc[$], rc[$], ri[$], rw[$];
      logic [OW-1:0] oa[$];
      logic [AW-1:0] od[$];
      exp_n    = (len == 0 || nout == 0) ? 0 : nout;
      exp_rd   = exp_n * len;
      exp_done = (exp_n == 0) ? 1 : nout*(len + 2) + 1;
      ndone = 0; busy_bad = 0; got_done = -1; first_out = '0;
      @(negedge clk);
      in_len = IW'(len); out_len = OW'(nout); relu_en = relu; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      in_len = IW'($urandom); out_len = OW'($urandom); relu_en = 1'($urandom);
      for (int c = 1; c <= exp_done + 4; c++) begin
         @(negedge clk);
         if (rd_en) begin rc.push_back(c); ri.push_back(int'(in_addr)); rw.push_back(int'(w_addr)); end
         if (out_valid) begin oc.push_back(c); oa.push_back(out_addr); od.push_back(out_data); end
         if (done) begin ndone++; got_done = c; end
         if (busy !== (c <= exp_done)) busy_bad++;
         start = (c == pulse_cyc);
         if (c == pulse_cyc) begin in_len = IW'($urandom); out_len = OW'($urandom); end
      end
      start = 1'b0;
      got_n = oc.size();
      if (got_n > 0) first_out = od[0];
      chk({tag, " done_count"}, ndone, 1);
      chk({tag, " done_cycle"}, got_done, exp_done);
      chk({tag, " busy_profile_errors"}, busy_bad, 0);
      chk({tag, " out_count"}, got_n, exp_n);
      for (int k = 0; k < got_n && k < exp_n; k++) begin
         chk($sformatf("%s out%0d_cycle", tag, k), oc[k], (k + 1)*(len + 2));
         chk($sformatf("%s out%0d_addr", tag, k), oa[k], k);
         chk($sformatf("%s out%0d_data", tag, k), od[k], model_out(len, k, relu));
      end
      chk({tag, " rd_count"}, rc.size(), exp_rd);
      for (int k = 0; k < rc.size() && k < exp_rd; k++) begin
         chk($sformatf("%s rd%0d_cycle", tag, k), rc[k], (k/len)*(len + 2) + 1 + k%len);
         chk($sformatf("%s rd%0d_in_addr", tag, k), ri[k], k%len);
         chk($sformatf("%s rd%0d_w_addr", tag, k), rw[k], k);
      end
   endtask

   typedef struct {
      int            len;
      int            nout;
      bit            relu;
      int            pat;
      logic [AW-1:0] exp0;
      int            exp_done;
      int            exp_n;
   } vec_t;

   initial begin
      vec_t          tbl [7];
      logic [AW-1:0] fo;
      int            gd, gn, stray, len, nout, pulse;

      tbl[0] = '{3, 1, 1'b0, 0, 40'd7,           6,  1};
      tbl[1] = '{3, 1, 1'b1, 1, 40'd0,           6,  1};
      tbl[2] = '{3, 1, 1'b0, 1, 40'hFFFFFFFFF7,  6,  1};
      tbl[3] = '{2, 3, 1'b0, 2, 40'd5,           13, 3};
      tbl[4] = '{1, 1, 1'b0, 3, 40'd0,           4,  1};
      tbl[5] = '{0, 5, 1'b0, 4, 40'd0,           1,  0};
      tbl[6] = '{4, 0, 1'b1, 4, 40'd0,           1,  0};

      repeat (3) @(negedge clk);
      chk("reset ctrl", {busy, done, rd_en, out_valid}, 0);
      chk("reset addr", {in_addr, w_addr, out_addr}, 0);
      chk("reset out_data", out_data, 0);
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         load_pat(tbl[v].pat);
         run_layer(tbl[v].len, tbl[v].nout, tbl[v].relu, 0, $sformatf("vec%0d", v), fo, gd, gn);
         chk($sformatf("vec%0d table_done", v), gd, tbl[v].exp_done);
         chk($sformatf("vec%0d table_n", v), gn, tbl[v].exp_n);
         if (tbl[v].exp_n > 0) chk($sformatf("vec%0d table_out0", v), fo, tbl[v].exp0);
      end

      // Start pulsed mid-layer must leave timing and result untouched.
      load_pat(0);
      run_layer(3, 1, 1'b0, 2, "pulse", fo, gd, gn);
      chk("pulse out0", fo, 40'd7);
      chk("pulse done", gd, 6);

      // Reset during neuron 1 aborts the layer; the next start runs cleanly.
      fill_random(4, 3);
      @(negedge clk);
      in_len = 4; out_len = 3; relu_en = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort pre busy_rd", {busy, rd_en}, 2'b11);
      chk("abort pre in_addr", in_addr, 1);
      chk("abort pre w_addr", w_addr, 5);
      rst_n = 1'b0;
      #1;
      chk("abort ctrl", {busy, done, rd_en, out_valid}, 0);
      chk("abort addr", {in_addr, w_addr, out_addr}, 0);
      chk("abort out_data", out_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid || done || busy) stray++;
      end
      chk("abort quiet", stray, 0);
      fill_random(4, 3);
      run_layer(4, 3, 1'b0, 0, "after_abort", fo, gd, gn);

      for (int it = 0; it < 30; it++) begin
         len   = $urandom_range(1, 8);
         nout  = $urandom_range(1, 4);
         pulse = (it % 3 == 0) ? $urandom_range(1, len) : 0;
         fill_random(len, nout);
         run_layer(len, nout, 1'($urandom), pulse, $sformatf("rand%0d", it), fo, gd, gn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
